fullconn_bp_layer_p: RTL

FULLCONN_BP_LAYER_P -- requirements
Module: fullconn_bp_layer_p

---
 rtl/fullconn_bp_layer_p.sv | 72 +++++++
 1 files changed

// File: rtl/fullconn_bp_layer_p.sv
// fullconn_bp_layer_p: stochastic fully-connected backprop layer with round-robin term select and frame accumulators
module fullconn_bp_layer_p #(
    parameter int N_IN       = 25,
    parameter int N_OUT      = 8,
    parameter int STREAM_LEN = 256,
    localparam int ACC_W     = $clog2(STREAM_LEN) + 2,
    localparam int SEL_W     = N_IN > 1 ? $clog2(N_IN) : 1
) (
    input  logic                    CLK,
    input  logic                    INIT,
    input  logic [N_IN*N_OUT-1:0]   alpha,
    input  logic [N_IN*N_OUT-1:0]   SIGN_alpha,
    input  logic [N_IN-1:0]         zp,
    input  logic [N_OUT-1:0]        delta_in,
    input  logic [N_OUT-1:0]        SIGN_delta_in,
    input  logic                    START,
    input  logic [SEL_W-1:0]        ACC_SEL,
    output logic [N_IN-1:0]         delta_out,
    output logic [N_IN-1:0]         SIGN_delta_out,
    output logic                    BUSY,
    output logic                    DONE,
    output logic signed [ACC_W-1:0] ACC_OUT
);
    localparam int OS_W = N_OUT > 1 ? $clog2(N_OUT) : 1;
    localparam int CNT_W = $clog2(STREAM_LEN);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2;
    logic [1:0] state;
    logic [OS_W-1:0] sel;
    logic [CNT_W-1:0] cnt;
    logic [N_IN-1:0] m, s;
    logic signed [ACC_W-1:0] acc [N_IN];
    for (genvar i = 0; i < N_IN; i++) begin : g_n
        int k;
        assign k = (int'(sel) + i) % N_OUT;
        assign m[i] = zp[i] & alpha[k*N_IN+i] & delta_in[k];
        assign s[i] = SIGN_alpha[k*N_IN+i] ^ SIGN_delta_in[k];
    end
    always_ff @(posedge CLK) begin
        if (INIT) begin
            delta_out <= '0;
            SIGN_delta_out <= '0;
        end else begin
            delta_out <= m;
            SIGN_delta_out <= s & m;
        end
    end
    always_ff @(posedge CLK) begin
        if (INIT) begin
            state <= IDLE;
            sel <= '0;
            cnt <= '0;
            for (int i = 0; i < N_IN; i++) acc[i] <= '0;
        end else begin
            sel <= (sel == OS_W'(N_OUT - 1)) ? '0 : sel + 1'b1;
            if (state == IDLE && START) begin
                state <= RUN;
                cnt <= '0;
                for (int i = 0; i < N_IN; i++) acc[i] <= '0;
            end else if (state == RUN) begin
                cnt <= cnt + 1'b1;
                for (int i = 0; i < N_IN; i++)
                    if (delta_out[i]) acc[i] <= SIGN_delta_out[i] ? acc[i] - ACC_W'(1) : acc[i] + ACC_W'(1);
                if (cnt == CNT_W'(STREAM_LEN - 1)) state <= FIN;
            end else if (state == FIN) begin
                state <= IDLE;
            end
        end
    end
    assign BUSY = state == RUN;
    assign DONE = state == FIN;
    assign ACC_OUT = (32'(ACC_SEL) < N_IN) ? acc[ACC_SEL] : '0;
endmodule
